vga_sync_receiver: RTL and testbench
====================================

# vga_sync_receiver

Receive-side counterpart of the VGA output chain: samples an incoming 640x480 VGA stream (hsync, vsync, 4-bit RGB) at pixel rate, recovers pixel/line coordinates from the sync edges, and validates the timing. It sits on the capture or loop-back path, in the same pixel-enable domain as the horizontal/vertical generators. After a configurable number of clean frames it declares lock, then qualifies each pixel as active/inactive.

## Interface
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, front porch pixels
- H_SYNC, 96, hsync pulse pixels
- H_BACK, 48, back porch pixels
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, front porch lines
- V_SYNC, 2, vsync pulse lines
- V_BACK, 33, back porch lines
- LOCK_FRAMES, 2, consecutive good frames required for lock (1..7)
- clk  in  1  system clock (50 MHz); one clock domain
- rst  in  1  reset, asynchronous, active-high
- clk_en  in  1  pixel-rate enable; all state advances only on cycles with clk_en=1
- hsync  in  1  horizontal sync, active-low
- vsync  in  1  vertical sync, active-low
- red, green, blue  in  4 each  incoming colour
- pixel_x  out  10  visible column, 0..H_VISIBLE-1
- line_y  out  10  visible row, 0..V_VISIBLE-1
- active  out  1  current outputs are a visible pixel and locked=1
- rgb_out  out  12  {red,green,blue} when active, else 0
- locked  out  1  timing lock
- frame_start  out  1  one-clk pulse at pixel (0,0) when locked
- timing_error  out  1  one-clk pulse on any check failure while locked

## Operation
- Edge detect: hsync_q/vsync_q registered on clk_en; fall = q=1 and input=0.
- H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525).
- h_cnt (10 b): cleared to 0 on hsync fall, else +1, saturates at 1023.
- v_cnt (10 b): cleared to 0 on vsync fall (takes priority over simultaneous hsync fall); else +1 on hsync fall; saturates at 1023.
- Visible: h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_VISIBLE-1] (144..783) and v_cnt in [V_SYNC+V_BACK, ...+V_VISIBLE-1] (35..514); pixel_x = h_cnt-144, line_y = v_cnt-35.
- Line check: on hsync fall, previous line bad if h_cnt != H_TOTAL-1. Frame check: on vsync fall, frame bad if v_cnt != V_TOTAL-1 or any bad line in it.
- FSM states:
  - SEARCH: wait for vsync fall -> MEASURE, good_cnt=0.
  - MEASURE: each vsync fall: good frame -> good_cnt+1, reaching LOCK_FRAMES -> LOCKED; bad frame -> good_cnt=0, stay.
  - LOCKED: first bad line or frame -> timing_error pulse, -> SEARCH immediately (same clk_en).
- h_cnt or v_cnt saturating counts as bad (lost sync).
- Outputs when not locked: active=0, rgb_out=0, pixel_x/line_y=0.

## Timing
- Reset values: pixel_x=0, line_y=0, active=0, rgb_out=0, locked=0, frame_start=0, timing_error=0; FSM=SEARCH, counters 0, hsync_q=vsync_q=1.
- Latency: registered outputs; coordinates/rgb_out correspond to inputs sampled on the previous clk_en cycle (1 pixel).
- frame_start and timing_error are exactly one clk wide, aligned to a clk_en cycle.
- locked rises on the clk_en cycle after the qualifying vsync fall; falls together with timing_error.
- clk_en=0: all registers hold; pulses deassert next clk.
- rst mid-frame: immediate return to reset values; relock needs a vsync fall plus LOCK_FRAMES good frames.

## Configuration
- VGA_RX_PULSE_CHECK_EN defined: also measure hsync low width; a line whose low width != H_SYNC is bad, and a vsync low width != V_SYNC lines makes the frame bad.
- Not defined: only line period and frame length checked; pulse widths ignored.

## Test plan
- Reset, then 3 ideal 800x525 frames, LOCK_FRAMES=2 -> locked=1 after 2nd vsync fall following first; frame_start each subsequent frame.
- Locked, drive pixel with rgb=12'hF0A at h_cnt=144,v_cnt=35 -> next clk_en: pixel_x=0, line_y=0, active=1, rgb_out=12'hF0A; at h_cnt=784 -> active=0, rgb_out=0.
- Locked, one line of 799 pixels -> timing_error pulse, locked=0, outputs 0; relock after 2 more clean frames.
- Frame of 524 lines in MEASURE -> good_cnt reset, lock delayed by one frame.
- Hold hsync high 1100 clk_en -> h_cnt saturates at 1023, lock dropped.
- With VGA_RX_PULSE_CHECK_EN, hsync pulse 95 wide, period 800 -> timing_error; without macro -> lock retained.

Source files
------------

// File: rtl/vga_sync_receiver_if.sv
// vga_sync_receiver_if: incoming VGA stream (pixel enable, syncs, colour) and the recovered timing/pixel results
interface vga_sync_receiver_if;
  logic clk_en;
  logic hsync;
  logic vsync;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic [9:0] pixel_x;
  logic [9:0] line_y;
  logic active;
  logic [11:0] rgb_out;
  logic locked;
  logic frame_start;
  logic timing_error;
  modport master(
    output clk_en, hsync, vsync, red, green, blue,
    input pixel_x, line_y, active, rgb_out, locked, frame_start, timing_error
  );
  modport slave(
    input clk_en, hsync, vsync, red, green, blue,
    output pixel_x, line_y, active, rgb_out, locked, frame_start, timing_error
  );
endinterface

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: recovers VGA pixel/line coordinates from sync edges, validates timing, locks and qualifies active pixels
//   clk, rst (async, active-high); vif.slave: clk_en, hsync/vsync (active-low), red/green/blue in;
//   pixel_x, line_y, active, rgb_out, locked, frame_start, timing_error out (registered, one pixel latency).
//   Define VGA_RX_PULSE_CHECK_EN to also require hsync low for H_SYNC pixels and vsync low for V_SYNC lines.
module vga_sync_receiver #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC = 96,
  parameter int H_BACK = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC = 2,
  parameter int V_BACK = 33,
  parameter int LOCK_FRAMES = 2
) (
  input logic clk,
  input logic rst,
  vga_sync_receiver_if.slave vif
);
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] H_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_END = 10'(H_SYNC + H_BACK + H_VISIBLE - 1);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_END = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);
  localparam logic [9:0] SAT = 10'h3ff;
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  state_t state;
  logic [2:0] good_cnt;
  logic hsync_q, vsync_q, frame_bad;
  logic [9:0] h_cnt, v_cnt, h_nx, v_nx;
  logic hfall, vfall, bad_now, len_bad, frame_ok, err, promote, lock_nx, vis;
  // h_nx/v_nx are the coordinates of the sample being taken now; h_cnt/v_cnt hold the previous sample's
  always_comb begin
    hfall = hsync_q & ~vif.hsync;
    vfall = vsync_q & ~vif.vsync;
    h_nx = hfall ? '0 : ((h_cnt == SAT) ? SAT : h_cnt + 10'd1);
    v_nx = vfall ? '0 : ((hfall && v_cnt != SAT) ? v_cnt + 10'd1 : v_cnt);
    bad_now = (hfall && h_cnt != 10'(H_TOTAL - 1)) || (!hfall && h_cnt == SAT) || (!vfall && v_cnt == SAT);
`ifdef VGA_RX_PULSE_CHECK_EN
    bad_now = bad_now || ((~hsync_q & vif.hsync) && h_cnt != 10'(H_SYNC - 1))
                      || ((~vsync_q & vif.vsync) && v_cnt != 10'(V_SYNC - 1));
`endif
    len_bad = vfall && v_cnt != 10'(V_TOTAL - 1);
    frame_ok = !(frame_bad || bad_now || len_bad);
    err = (state == LOCKED) && (bad_now || len_bad);
    promote = (state == MEASURE) && vfall && frame_ok && (good_cnt + 3'd1 == 3'(LOCK_FRAMES));
    lock_nx = ((state == LOCKED) && !err) || promote;
    vis = lock_nx && h_nx >= H_START && h_nx <= H_END && v_nx >= V_START && v_nx <= V_END;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= SEARCH;
      good_cnt <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      frame_bad <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
      vif.pixel_x <= '0;
      vif.line_y <= '0;
      vif.active <= 1'b0;
      vif.rgb_out <= '0;
      vif.locked <= 1'b0;
      vif.frame_start <= 1'b0;
      vif.timing_error <= 1'b0;
    end else begin
      vif.frame_start <= 1'b0;
      vif.timing_error <= 1'b0;
      if (vif.clk_en) begin
        hsync_q <= vif.hsync;
        vsync_q <= vif.vsync;
        h_cnt <= h_nx;
        v_cnt <= v_nx;
        frame_bad <= !vfall && (frame_bad || bad_now);
        case (state)
          SEARCH: if (vfall) begin
            state <= MEASURE;
            good_cnt <= '0;
          end
          MEASURE: if (vfall) begin
            good_cnt <= frame_ok ? good_cnt + 3'd1 : '0;
            if (promote) state <= LOCKED;
          end
          LOCKED: if (err) state <= SEARCH;
          default: state <= SEARCH;
        endcase
        vif.locked <= lock_nx;
        vif.timing_error <= err;
        vif.active <= vis;
        vif.pixel_x <= vis ? h_nx - H_START : '0;
        vif.line_y <= vis ? v_nx - V_START : '0;
        vif.rgb_out <= vis ? {vif.red, vif.green, vif.blue} : '0;
        vif.frame_start <= vis && h_nx == H_START && v_nx == V_START;
      end
    end
endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: randomized VGA stream with a frame-level reference model and scoreboard
module tb_vga_sync_receiver;
  localparam int H_VISIBLE = 16, H_FRONT = 2, H_SYNC = 4, H_BACK = 3;
  localparam int V_VISIBLE = 6, V_FRONT = 1, V_SYNC = 2, V_BACK = 2;
  localparam int LOCK_FRAMES = 2;
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int H0 = H_SYNC + H_BACK;
  localparam int V0 = V_SYNC + V_BACK;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic act;
    logic [11:0] rgb;
    logic lk;
    logic fs;
    logic te;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_q = 1'b0;
  exp_t q[$];
  exp_t last = '0;
  int vectors = 0;
  int miscompares = 0;
  int st = 0;
  int good = 0;
  int run = 0;
  int lines = 0;
  logic fbad = 1'b0;
  logic line_ok = 1'b0;
  logic frame_ok = 1'b0;
  vga_sync_receiver_if vif();
  vga_sync_receiver #(
    .H_VISIBLE(H_VISIBLE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_VISIBLE(V_VISIBLE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK),
    .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vif(vif)
  );
  always #5 clk = ~clk;
  always @(posedge clk) en_q <= vif.clk_en;
  task automatic chk(input exp_t e, input string nm);
    exp_t a;
    a = {vif.pixel_x, vif.line_y, vif.active, vif.rgb_out, vif.locked, vif.frame_start, vif.timing_error};
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s @%0t: got x=%0d y=%0d act=%b rgb=%h locked=%b fs=%b te=%b, want x=%0d y=%0d act=%b rgb=%h locked=%b fs=%b te=%b",
               nm, $time, a.x, a.y, a.act, a.rgb, a.lk, a.fs, a.te, e.x, e.y, e.act, e.rgb, e.lk, e.fs, e.te);
    end
  endtask
  always @(negedge clk)
    if (rst) begin
      chk('0, "reset");
      last = '0;
    end else if (en_q) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL scoreboard @%0t: enabled sample with no expectation queued", $time);
      end else begin
        last = q.pop_front();
        chk(last, "pixel");
        last.fs = 1'b0;
        last.te = 1'b0;
      end
    end else chk(last, "hold");
  task automatic sample(input int p, input int l, input int hw);
    exp_t e;
    logic fs_ev, bad, err, lk, vis;
    logic [11:0] c;
    while ($urandom_range(0, 3) == 0) begin
      vif.clk_en = 1'b0;
      vif.hsync = 1'($urandom);
      vif.vsync = 1'($urandom);
      {vif.red, vif.green, vif.blue} = 12'($urandom);
      @(posedge clk);
      #1;
    end
    c = (p == H0 && l == V0) ? 12'hF0A : 12'($urandom);
    vif.clk_en = 1'b1;
    vif.hsync = (p >= hw);
    vif.vsync = (l >= V_SYNC);
    {vif.red, vif.green, vif.blue} = c;
    fs_ev = (p == 0 && l == 0);
    if (p == 0) begin
      line_ok = (run == H_TOTAL);
      run = 0;
    end
    run++;
    if (fs_ev) begin
      frame_ok = (lines == V_TOTAL);
      lines = 0;
    end
    if (p == 0) lines++;
    bad = (p == 0 && !line_ok) || p >= 1024;
`ifdef VGA_RX_PULSE_CHECK_EN
    bad = bad || (p == hw && hw != H_SYNC);
`endif
    err = 1'b0;
    if (st == 2) begin
      if (bad || (fs_ev && !frame_ok)) begin
        err = 1'b1;
        st = 0;
      end
    end else if (fs_ev) begin
      if (st == 0) begin
        st = 1;
        good = 0;
      end else if (fbad || bad || !frame_ok) good = 0;
      else begin
        good++;
        if (good == LOCK_FRAMES) st = 2;
      end
    end
    fbad = !fs_ev && (fbad || bad);
    lk = (st == 2);
    vis = lk && p >= H0 && p < H0 + H_VISIBLE && l >= V0 && l < V0 + V_VISIBLE;
    e.x = vis ? 10'(p - H0) : '0;
    e.y = vis ? 10'(l - V0) : '0;
    e.act = vis;
    e.rgb = vis ? c : '0;
    e.lk = lk;
    e.fs = vis && p == H0 && l == V0;
    e.te = err;
    q.push_back(e);
    @(posedge clk);
    #1;
    vif.clk_en = 1'b0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    st = 0;
    good = 0;
    fbad = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic send_frame(input int nl, input int sl, input int slen, input int shw, input int rl);
    for (int l = 0; l < nl; l++) begin
      int len, hw;
      len = (l == sl) ? slen : H_TOTAL;
      hw = (l == sl) ? shw : H_SYNC;
      for (int p = 0; p < len; p++) begin
        if (l == rl && p == H0 + 2) do_reset();
        sample(p, l, hw);
      end
    end
  endtask
  task automatic clean(input int n);
    repeat (n) send_frame(V_TOTAL, -1, 0, H_SYNC, -1);
  endtask
  initial begin
    #3_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end
  initial begin
    vif.clk_en = 1'b0;
    vif.hsync = 1'b1;
    vif.vsync = 1'b1;
    {vif.red, vif.green, vif.blue} = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    clean(4);
    send_frame(V_TOTAL, 5, H_TOTAL - 1, H_SYNC, -1);
    clean(4);
    send_frame(V_TOTAL, 3, H_TOTAL - 1, H_SYNC, -1);
    clean(1);
    send_frame(V_TOTAL - 1, -1, 0, H_SYNC, -1);
    clean(4);
    send_frame(V_TOTAL, 3, 1100, H_SYNC, -1);
    clean(4);
    send_frame(V_TOTAL, 3, H_TOTAL, H_SYNC - 1, -1);
    clean(2);
    send_frame(V_TOTAL, -1, 0, H_SYNC, 5);
    clean(4);
    for (int i = 0; i < 10; i++)
      if ($urandom_range(0, 1) == 0) clean(1);
      else send_frame(int'($urandom_range(V_TOTAL - 1, V_TOTAL + 1)), int'($urandom_range(0, V_TOTAL - 2)),
                      int'($urandom_range(H_TOTAL - 1, H_TOTAL + 1)), int'($urandom_range(H_SYNC - 1, H_SYNC)), -1);
    clean(3);
    vif.clk_en = 1'b0;
    repeat (4) @(posedge clk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
